// File: rtl/scurve_pkg.sv
// Shared types and constants for the S-curve test engines.
// Optional build macro used by the engine: SCURVE_INJ_COUNT_OUT_EN.
package scurve_pkg;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] SCURVE_TEST_HEADER = 16'h5343;

  // Binary FSM encoding kept as plain constants for compatibility with older blocks
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_PULSE_HIGH = 3'd1;
  localparam state_t ST_PULSE_LOW  = 3'd2;
  localparam state_t ST_CHECK      = 3'd3;
  localparam state_t ST_WRITE      = 3'd4;
  localparam state_t ST_DONE       = 3'd5;

endpackage

// File: rtl/trigger_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector with a registered one-cycle strobe.
// Input edge to strobe output latency is three Clk cycles.
module trigger_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   strobe_reg;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg   <= '0;
      prev_reg   <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg   <= sync_reg[SYNC_STAGES-1];
      strobe_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign strobe = strobe_reg;

endmodule

// File: rtl/scurve_single_test_engine.sv
// Single S-curve point: fires Pulse_Count CTest injections, counts windowed triggers, writes the FIFO.
// Define SCURVE_INJ_COUNT_OUT_EN to emit the injection count ahead of the trigger count.
module scurve_single_test_engine
  import scurve_pkg::*;
#(
  parameter int PULSE_HIGH_CYCLES   = 8,
  parameter int PULSE_PERIOD_CYCLES = 400,
  parameter int TRIG_WINDOW_CYCLES  = 40
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               Single_Test_Start,
  input  logic               Test_Abort,
  input  logic [COUNT_W-1:0] Pulse_Count,
  input  logic               Trigger_In,
  output logic               CTest_Pulse,
  input  logic               SCurve_Data_fifo_full,
  output logic               SCurve_Data_fifo_wr_en,
  output logic [COUNT_W-1:0] SCurve_Data_fifo_wr_din,
  output logic               Single_Test_Done,
  output logic               Busy
);

  localparam int PHASE_W = $clog2(PULSE_PERIOD_CYCLES);
  localparam logic [PHASE_W-1:0] PH_HIGH_END = PHASE_W'(PULSE_HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PH_LOW_END  = PHASE_W'(PULSE_PERIOD_CYCLES - 2);
  localparam logic [PHASE_W-1:0] PH_WINDOW   = PHASE_W'(TRIG_WINDOW_CYCLES);

  state_t               state_reg, state_next;
  logic [PHASE_W-1:0]   phase_reg, phase_next;
  logic [COUNT_W-1:0]   count_reg, count_next;
  logic [COUNT_W-1:0]   inj_cnt_reg, inj_cnt_next;
  logic [COUNT_W-1:0]   trig_cnt_reg, trig_cnt_next;
  logic                 hit_reg, hit_next;
  logic                 pulse_reg;
  logic                 wr_en;
  logic [COUNT_W-1:0]   wr_word;
  logic                 trig_strobe;
`ifdef SCURVE_INJ_COUNT_OUT_EN
  logic                 word_sel_reg, word_sel_next;
`endif

  trigger_sync_edge #(
    .SYNC_STAGES (2)
  ) u_trig_sync (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .async_in (Trigger_In),
    .strobe   (trig_strobe)
  );

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    count_next    = count_reg;
    inj_cnt_next  = inj_cnt_reg;
    trig_cnt_next = trig_cnt_reg;
    hit_next      = hit_reg;
    wr_en         = 1'b0;
`ifdef SCURVE_INJ_COUNT_OUT_EN
    word_sel_next = word_sel_reg;
    wr_word       = word_sel_reg ? trig_cnt_reg : inj_cnt_reg;
`else
    wr_word       = trig_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (Single_Test_Start) begin
          count_next    = Pulse_Count;
          inj_cnt_next  = '0;
          trig_cnt_next = '0;
          hit_next      = 1'b0;
          phase_next    = '0;
          state_next    = (Pulse_Count == '0) ? ST_WRITE : ST_PULSE_HIGH;
        end
      end

      ST_PULSE_HIGH, ST_PULSE_LOW: begin
        if (trig_strobe && !hit_reg && (phase_reg < PH_WINDOW)) begin
          trig_cnt_next = trig_cnt_reg + 1'b1;
          hit_next      = 1'b1;
        end
        phase_next = phase_reg + 1'b1;
        // CHECK occupies the last phase slot so the period stays exact
        if (phase_reg == PH_LOW_END)
          state_next = ST_CHECK;
        else if (phase_reg >= PH_HIGH_END)
          state_next = ST_PULSE_LOW;
        else
          state_next = ST_PULSE_HIGH;
      end

      ST_CHECK: begin
        inj_cnt_next = inj_cnt_reg + 1'b1;
        if (inj_cnt_next == count_reg) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_PULSE_HIGH;
          phase_next = '0;
          hit_next   = 1'b0;
        end
      end

      ST_WRITE: begin
        if (!SCurve_Data_fifo_full) begin
          wr_en = 1'b1;
`ifdef SCURVE_INJ_COUNT_OUT_EN
          word_sel_next = ~word_sel_reg;
          if (word_sel_reg)
            state_next = ST_DONE;
`else
          state_next = ST_DONE;
`endif
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase

    // Abort overrides every transition and suppresses any write in flight
    if (Test_Abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      wr_en      = 1'b0;
`ifdef SCURVE_INJ_COUNT_OUT_EN
      word_sel_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= '0;
      count_reg    <= '0;
      inj_cnt_reg  <= '0;
      trig_cnt_reg <= '0;
      hit_reg      <= 1'b0;
      pulse_reg    <= 1'b0;
`ifdef SCURVE_INJ_COUNT_OUT_EN
      word_sel_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      count_reg    <= count_next;
      inj_cnt_reg  <= inj_cnt_next;
      trig_cnt_reg <= trig_cnt_next;
      hit_reg      <= hit_next;
      pulse_reg    <= (state_next == ST_PULSE_HIGH);
`ifdef SCURVE_INJ_COUNT_OUT_EN
      word_sel_reg <= word_sel_next;
`endif
    end
  end

  assign CTest_Pulse             = pulse_reg;
  assign SCurve_Data_fifo_wr_en  = wr_en;
  assign SCurve_Data_fifo_wr_din = wr_en ? wr_word : '0;
  assign Single_Test_Done        = (state_reg == ST_DONE) && !Test_Abort;
  assign Busy                    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_scurve_single_test_engine.sv
// Self-checking bench: vector table of test points, FIFO word scoreboard, abort and reset sequences.
module tb_scurve_single_test_engine;

  localparam int HI  = 8;
  localparam int PER = 400;

  typedef struct {
    int pc;
    int mode;       // 0 no triggers, 1 every injection, 2 odd injections only
    bit extra;      // additional late trigger at phase ~200
    int full_hold;  // cycles to keep FIFO full once WRITE is reached
    int exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        Single_Test_Start;
  logic        Test_Abort;
  logic [15:0] Pulse_Count;
  logic        Trigger_In;
  logic        CTest_Pulse;
  logic        SCurve_Data_fifo_full;
  logic        SCurve_Data_fifo_wr_en;
  logic [15:0] SCurve_Data_fifo_wr_din;
  logic        Single_Test_Done;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int last_rise = 0;
  int last_write = -10;
  int done_count = 0;
  int trig_mode = 0;
  bit extra_trig = 1'b0;
  int drv_idx = 0;
  bit cut_ok = 1'b0;
  logic prev_pulse = 1'b0;
  logic [15:0] sb[$];

  scurve_single_test_engine #(
    .PULSE_HIGH_CYCLES   (HI),
    .PULSE_PERIOD_CYCLES (PER),
    .TRIG_WINDOW_CYCLES  (40)
  ) dut (
    .Clk                     (Clk),
    .reset_n                 (reset_n),
    .Single_Test_Start       (Single_Test_Start),
    .Test_Abort              (Test_Abort),
    .Pulse_Count             (Pulse_Count),
    .Trigger_In              (Trigger_In),
    .CTest_Pulse             (CTest_Pulse),
    .SCurve_Data_fifo_full   (SCurve_Data_fifo_full),
    .SCurve_Data_fifo_wr_en  (SCurve_Data_fifo_wr_en),
    .SCurve_Data_fifo_wr_din (SCurve_Data_fifo_wr_din),
    .Single_Test_Done        (Single_Test_Done),
    .Busy                    (Busy)
  );

  initial forever #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Behavioural Microroc: answers each CTest rise with a trigger a few cycles later
  initial begin
    Trigger_In = 1'b0;
    forever begin
      @(posedge CTest_Pulse);
      drv_idx++;
      repeat (5) @(posedge Clk);
      #1 Trigger_In = (trig_mode == 1) || (trig_mode == 2 && drv_idx[0]);
      repeat (2) @(posedge Clk);
      #1 Trigger_In = 1'b0;
      if (extra_trig) begin
        repeat (193) @(posedge Clk);
        #1 Trigger_In = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Trigger_In = 1'b0;
      end
    end
  end

  // Output monitor: pulse shape, FIFO scoreboard, Done timing
  always @(negedge Clk) begin
    if (reset_n === 1'b1) begin
      if (CTest_Pulse && !prev_pulse) begin
        if (rises > 0) chk("pulse_period", cyc - last_rise, PER);
        rises++;
        last_rise = cyc;
      end
      if (!CTest_Pulse && prev_pulse && !cut_ok)
        chk("pulse_high_len", cyc - last_rise, HI);
      prev_pulse = CTest_Pulse;
      if (SCurve_Data_fifo_wr_en) begin
        $display("fifo write din=%0d cycle=%0d", SCurve_Data_fifo_wr_din, cyc);
        chk("write_expected", sb.size() > 0, 1);
        chk("write_while_full", SCurve_Data_fifo_full, 0);
        if (sb.size() > 0) chk("fifo_word", SCurve_Data_fifo_wr_din, sb.pop_front());
        last_write = cyc;
      end
      if (Single_Test_Done) begin
        chk("done_after_write", cyc, last_write + 1);
        done_count++;
      end
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic start_test(input int pc);
    @(posedge Clk);
    #1 Pulse_Count = 16'(pc);
    Single_Test_Start = 1'b1;
    @(posedge Clk);
    #1 Single_Test_Start = 1'b0;
  endtask

  task automatic run_test(input int idx, input vec_t v);
    int d0, start_cyc, nwords, budget;
    trig_mode  = v.mode;
    extra_trig = v.extra;
    drv_idx    = 0;
    rises      = 0;
    cut_ok     = 1'b0;
`ifdef SCURVE_INJ_COUNT_OUT_EN
    sb.push_back(16'(v.pc));
    nwords = 2;
`else
    nwords = 1;
`endif
    sb.push_back(16'(v.exp));
    SCurve_Data_fifo_full = (v.full_hold > 0);
    d0 = done_count;
    start_test(v.pc);
    start_cyc = cyc - 1;
    if (v.pc > 0) begin
      @(negedge Clk);
      chk("busy_running", Busy, 1);
    end
    if (v.pc > 1) begin
      // A second start while busy must not reload the count
      repeat (100) @(posedge Clk);
      #1 Pulse_Count = 16'(v.pc + 7);
      Single_Test_Start = 1'b1;
      @(posedge Clk);
      #1 Single_Test_Start = 1'b0;
    end
    if (v.full_hold > 0) begin
      while (cyc < start_cyc + v.pc * PER + v.full_hold) @(posedge Clk);
      #1;
      chk("held_words_pending", sb.size(), nwords);
      SCurve_Data_fifo_full = 1'b0;
    end
    budget = v.pc * PER + 500;
    for (int i = 0; i < budget && done_count == d0; i++) @(negedge Clk);
    chk("done_count", done_count, d0 + 1);
    chk("sb_empty", sb.size(), 0);
    chk("injections", rises, v.pc);
    @(negedge Clk);
    chk("busy_after_done", Busy, 0);
    $display("test %0d pulse_count=%0d expected_word=%0d injections=%0d", idx, v.pc, v.exp, rises);
  endtask

  vec_t vecs[5];

  initial begin
    int d0;
    vecs[0] = '{pc: 10, mode: 1, extra: 1'b0, full_hold: 0,  exp: 10};
    vecs[1] = '{pc: 10, mode: 2, extra: 1'b1, full_hold: 0,  exp: 5};
    vecs[2] = '{pc: 0,  mode: 0, extra: 1'b0, full_hold: 0,  exp: 0};
    vecs[3] = '{pc: 3,  mode: 1, extra: 1'b0, full_hold: 50, exp: 3};
    vecs[4] = '{pc: 2,  mode: 0, extra: 1'b0, full_hold: 0,  exp: 0};

    reset_n = 1'b0;
    Single_Test_Start = 1'b0;
    Test_Abort = 1'b0;
    Pulse_Count = '0;
    SCurve_Data_fifo_full = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_ctest", CTest_Pulse, 0);
    chk("rst_wr_en", SCurve_Data_fifo_wr_en, 0);
    chk("rst_wr_din", SCurve_Data_fifo_wr_din, 0);
    chk("rst_done", Single_Test_Done, 0);
    chk("rst_busy", Busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 5; i++) run_test(i, vecs[i]);

    // Abort during the 4th injection of a long run
    trig_mode = 1; extra_trig = 1'b0; drv_idx = 0; rises = 0; cut_ok = 1'b1;
    d0 = done_count;
    start_test(100);
    for (int i = 0; i < 5000 && rises < 4; i++) @(negedge Clk);
    chk("abort_reached_inj4", rises, 4);
    Test_Abort = 1'b1;
    @(negedge Clk);
    chk("abort_ctest_low", CTest_Pulse, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done_low", Single_Test_Done, 0);
    Test_Abort = 1'b0;
    repeat (1000) @(negedge Clk);
    chk("abort_no_done", done_count, d0);
    chk("abort_no_more_pulses", rises, 4);
    $display("test abort pulse_count=100 injections=%0d", rises);

    // Asynchronous reset in the middle of a run
    rises = 0; drv_idx = 0;
    d0 = done_count;
    start_test(5);
    for (int i = 0; i < 2000 && rises < 2; i++) @(negedge Clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctest", CTest_Pulse, 0);
    chk("async_rst_busy", Busy, 0);
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (500) @(negedge Clk);
    chk("rst_no_done", done_count, d0);
    chk("rst_idle", Busy, 0);
    $display("test reset pulse_count=5 injections_before_reset=%0d", rises);
    cut_ok = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog timeout cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
